// File: rtl/fde_pkg.sv
// Shared state encoding and default sizing for the fetch/decode/execute sequencer.
`default_nettype none

package fde_pkg;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // States that launch a sub-block and wait for its done pulse.
  function automatic logic is_stage(input state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fde_stage_timer.sv
// Per-stage wait counter; cleared on stage entry, saturates at TIMEOUT-1 and flags expiry.
`default_nettype none

module fde_stage_timer
  import fde_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Count is 0 on the entry cycle, so expiry lands on the TIMEOUT-th cycle in the stage.
  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/fde_sequencer.sv
// Fetch/decode/execute run controller: sequences three sub-blocks per instruction
// until the program stops running, hits its instruction limit, or a stage times out.
`default_nettype none

module fde_sequencer
  import fde_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [PC_W-1:0]  start_pc,
  input  logic [CNT_W-1:0] max_instr,
  output logic             fetch_start,
  output logic             decode_start,
  output logic             exec_start,
  input  logic             fetch_done,
  input  logic             decode_done,
  input  logic             exec_done,
  output logic [PC_W-1:0]  fetch_pc,
  input  logic [PC_W-1:0]  exec_next_pc,
  input  logic             exec_running,
  output logic [CNT_W-1:0] instr_count,
  output logic             err_timeout
);

  state_t           state;
  state_t           next_state;
  logic             first;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] limit;
  logic             running;

  logic             stage_enter;
  logic             launch;
  logic             exec_accept;
  logic             timeout_hit;
  logic             expired;

  fde_stage_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (stage_enter),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Done inputs are qualified with !first so a pulse coincident with start is ignored.
  always_comb begin
    next_state  = state;
    exec_accept = 1'b0;
    timeout_hit = 1'b0;
    launch      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ap_start) begin
          launch     = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_done && !first) begin
          next_state = ST_DECODE;
        end else if (expired) begin
          timeout_hit = 1'b1;
          next_state  = ST_DONE;
        end
      end
      ST_DECODE: begin
        if (decode_done && !first) begin
          next_state = ST_EXEC;
        end else if (expired) begin
          timeout_hit = 1'b1;
          next_state  = ST_DONE;
        end
      end
      ST_EXEC: begin
        if (exec_done && !first) begin
          exec_accept = 1'b1;
          next_state  = ST_CHECK;
        end else if (expired) begin
          timeout_hit = 1'b1;
          next_state  = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (!running || ((limit != '0) && (instr_count == limit))) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_FETCH;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    stage_enter = is_stage(next_state) && (next_state != state);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      first       <= 1'b0;
      pc          <= '0;
      limit       <= '0;
      instr_count <= '0;
      running     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      first <= stage_enter;
      if (launch) begin
        pc          <= start_pc;
        limit       <= max_instr;
        instr_count <= '0;
        err_timeout <= 1'b0;
      end
      if (exec_accept) begin
        pc          <= exec_next_pc;
        instr_count <= instr_count + 1'b1;
        running     <= exec_running;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign fetch_start  = (state == ST_FETCH)  && first;
  assign decode_start = (state == ST_DECODE) && first;
  assign exec_start   = (state == ST_EXEC)   && first;
  assign ap_done      = (state == ST_DONE);
  assign ap_ready     = (state == ST_DONE);
  assign ap_idle      = (state == ST_IDLE);
  assign fetch_pc     = pc;

endmodule

`default_nettype wire

// File: tb/tb_fde_sequencer.sv
// Scoreboard bench for fde_sequencer: directed runs with hand-computed fetch PCs and done timing.
`default_nettype none

module tb_fde_sequencer;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;
  localparam int TMO   = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ap_start = 1'b0;
  logic             ap_done, ap_idle, ap_ready;
  logic [PC_W-1:0]  start_pc = '0;
  logic [CNT_W-1:0] max_instr = '0;
  logic             fetch_start, decode_start, exec_start;
  logic             fetch_done = 1'b0, decode_done = 1'b0, exec_done = 1'b0;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  exec_next_pc = '0;
  logic             exec_running = 1'b0;
  logic [CNT_W-1:0] instr_count;
  logic             err_timeout;

  fde_sequencer #(
    .PC_W    (PC_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .start_pc     (start_pc),
    .max_instr    (max_instr),
    .fetch_start  (fetch_start),
    .decode_start (decode_start),
    .exec_start   (exec_start),
    .fetch_done   (fetch_done),
    .decode_done  (decode_done),
    .exec_done    (exec_done),
    .fetch_pc     (fetch_pc),
    .exec_next_pc (exec_next_pc),
    .exec_running (exec_running),
    .instr_count  (instr_count),
    .err_timeout  (err_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int count;
    bit err;
  } done_exp_t;

  done_exp_t   done_q[$];
  logic [31:0] fetch_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Sub-block behaviour knobs
  int fetch_dly    = 1;
  bit fetch_early  = 0;
  bit decode_never = 0;
  bit exec_run     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(negedge clock);
    fetch_done = 1'b0;
    if (fetch_start) begin
      if (fetch_early) fetch_done = 1'b1;
      repeat (fetch_dly) begin
        @(negedge clock);
        fetch_done = 1'b0;
      end
      fetch_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge clock);
    decode_done = 1'b0;
    if (decode_start && !decode_never) begin
      @(negedge clock);
      decode_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge clock);
    exec_done = 1'b0;
    if (exec_start) begin
      @(negedge clock);
      exec_done    = 1'b1;
      exec_next_pc = fetch_pc + 32'd4;
      exec_running = exec_run;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch or a run completion.
  logic [31:0] last_fetch;
  bit          fetch_hold_chk = 0;
  initial forever begin
    @(negedge clock);
    if (fetch_hold_chk) begin
      check("fetch_pc_stable", fetch_pc, last_fetch);
      fetch_hold_chk = 0;
    end
    if (fetch_start) begin
      if (fetch_q.size() == 0) begin
        n_total++;
        $display("FAIL fetch_unexpected: got fetch_start with pc 0x%0h, required none (cycle %0d)", fetch_pc, cyc);
      end else begin
        last_fetch = fetch_q.pop_front();
        check("fetch_pc", fetch_pc, last_fetch);
        fetch_hold_chk = 1;
      end
    end
    if (ap_done) begin
      if (done_q.size() == 0) begin
        n_total++;
        $display("FAIL done_unexpected: got ap_done at cycle %0d, required none", cyc);
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_instr_count", instr_count, e.count);
        check("done_err_timeout", err_timeout, e.err);
        check("done_ap_ready", ap_ready, 1);
        check("done_ap_idle", ap_idle, 0);
      end
    end
  end

  task automatic launch(input logic [31:0] pc, input logic [31:0] mx);
    start_pc  = pc;
    max_instr = mx;
    ap_start  = 1'b1;
    @(negedge clock);
    ap_start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((done_q.size() != 0 || !ap_idle) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("run_completes", (done_q.size() == 0) && ap_idle, 1);
    @(negedge clock);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clock);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_ap_done", ap_done, 0);
    check("rst_instr_count", instr_count, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single instruction that stops running: done 8 cycles after ap_start
    exec_run = 0;
    c = cyc;
    fetch_q.push_back(32'h100);
    done_q.push_back('{cyc: c + 8, count: 1, err: 0});
    launch(32'h100, 0);
    wait_idle(100);

    // Three-instruction limit with sequential PCs
    exec_run = 1;
    c = cyc;
    fetch_q.push_back(32'h100);
    fetch_q.push_back(32'h104);
    fetch_q.push_back(32'h108);
    done_q.push_back('{cyc: c + 22, count: 3, err: 0});
    launch(32'h100, 3);
    wait_idle(200);

    // Decode never completes: timeout 16 cycles after decode_start
    decode_never = 1;
    c = cyc;
    fetch_q.push_back(32'h200);
    done_q.push_back('{cyc: c + 19, count: 0, err: 1});
    launch(32'h200, 0);
    wait_idle(200);
    check("timeout_sticky", err_timeout, 1);
    decode_never = 0;

    // Early fetch_done ignored; real one 3 cycles later
    fetch_early = 1;
    fetch_dly   = 3;
    exec_run    = 0;
    c = cyc;
    fetch_q.push_back(32'h300);
    done_q.push_back('{cyc: c + 10, count: 1, err: 0});
    launch(32'h300, 0);
    check("timeout_cleared_on_start", err_timeout, 0);
    wait_idle(200);
    fetch_early = 0;
    fetch_dly   = 1;

    // Reset during EXEC of the second instruction
    exec_run = 1;
    fetch_q.push_back(32'h400);
    fetch_q.push_back(32'h404);
    launch(32'h400, 0);
    repeat (11) @(negedge clock);
    check("pre_reset_exec_start", exec_start, 1);
    check("pre_reset_instr_count", instr_count, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("post_reset_ap_idle", ap_idle, 1);
    check("post_reset_instr_count", instr_count, 0);
    check("post_reset_fetch_pc", fetch_pc, 0);
    check("post_reset_ap_done", ap_done, 0);
    repeat (20) @(negedge clock);
    check("post_reset_still_idle", ap_idle, 1);
    check("fetch_queue_drained", fetch_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
